mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive D grants while I waits before I is forced (legal range 1..7).
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on posedge clk.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port i_re  in  1  instruction-fetch read request; held until i_complete.
REQ-005 SHALL have port i_addr  in  32  fetch byte address.
REQ-006 SHALL have port i_dout  out  32  fetch read data.
REQ-007 SHALL have port i_complete  out  1  fetch transaction done.
REQ-008 SHALL have port d_re  in  1  data load request; held until d_complete.
REQ-009 SHALL have port d_we  in  1  data store request; held until d_complete.
REQ-010 SHALL have port d_addr  in  32  data byte address.
REQ-011 SHALL have port d_din  in  32  store data.
REQ-012 SHALL have port d_dout  out  32  load data.
REQ-013 SHALL have port d_complete  out  1  data transaction done.
REQ-014 SHALL have ports mem_re, mem_we (out, 1 each), mem_addr (out, 32) and mem_din (out, 32), which drive the shared cache port.
REQ-015 SHALL have ports mem_dout (in, 32) and mem_complete (in, 1), which return from the cache; mem_complete may be combinational on a hit.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement the states IDLE, SERVE_I, SERVE_D and DONE, with a registered state.
REQ-018 IDLE: with no request pending, SHALL remain in IDLE with mem_re=mem_we=0.
REQ-019 IDLE: when exactly one port requests at the edge, SHALL go to SERVE_x and latch that port's addr, din, re and we into the mem_* registers.
REQ-020 IDLE, both ports requesting: SHALL grant D unless starve_cnt==STARVE_LIMIT, in which case it SHALL grant I.
REQ-021 The 3-bit starve_cnt SHALL increment when D is granted while i_re=1, saturating at 7.
REQ-022 starve_cnt SHALL clear to 0 on every I grant.
REQ-023 If d_we and d_re are both 1, the request SHALL be treated as a store (mem_we=1, mem_re=0).
REQ-024 I grants SHALL always drive mem_we=0.
REQ-025 SERVE_x: mem_* outputs SHALL be held stable, ignoring any requester input changes, until mem_complete is sampled high.
REQ-026 SERVE_x with mem_complete=1 at the edge: SHALL register x_dout<=mem_dout and x_complete<=1, clear mem_re/mem_we, and go to DONE.
REQ-027 DONE: SHALL hold x_complete high for exactly one cycle, then clear it and return to IDLE; the requester drops its request at the edge leaving DONE.
REQ-028 Requests SHALL never be sampled in SERVE or DONE, so one idle cycle minimum separates back-to-back transactions.
REQ-029 Minimum latency on a cache hit: request sampled at edge k, mem_re high during cycle k+1, x_complete high during cycle k+2.
REQ-030 x_dout SHALL hold its last value until the next completion on the same port.
REQ-031 d_dout after a store SHALL be don't-care.
REQ-032 The non-granted port's complete SHALL stay 0 throughout.
REQ-033 mem_din SHALL be 0 on I grants.
REQ-034 Miss latency SHALL be unbounded; the arbiter SHALL wait in SERVE_x without timeout.

Reset
REQ-035 rst=1 at an edge SHALL force state=IDLE, starve_cnt=0, all mem_* outputs=0, i_complete=d_complete=0, i_dout=d_dout=0 and busy=0.
REQ-036 Reset mid-transaction SHALL abandon the transaction and generate no complete pulse.
REQ-037 The first request is sampled at the first edge with rst=0.

Verification
REQ-038 Single I hit: i_re=1, i_addr=0x100, mem_complete=1 with mem_dout=0xDEADBEEF -> i_complete high in cycle k+2, i_dout=0xDEADBEEF, d_complete=0 throughout.
REQ-039 Store miss: d_we=1, d_addr=0x204, d_din=0x55AA, mem_complete delayed 10 cycles -> mem_we=1 and mem_addr=0x204 stable for all 10 cycles, then one d_complete pulse.
REQ-040 Contention and starvation, STARVE_LIMIT=4: i_re and d_re held high continuously -> grant order D,D,D,D,I,D,... and starve_cnt returns to 0 after the I grant.
REQ-041 d_we=d_re=1 with d_addr=0x40 -> mem_we=1, mem_re=0.
REQ-042 Reset pulsed in SERVE_D, 3 cycles into a miss -> next cycle all outputs 0, state IDLE, no d_complete, and a fresh request is served normally.
REQ-043 Address change during SERVE_I: i_addr changes 0x100 to 0x200 mid-miss -> mem_addr remains 0x100 until completion.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Shared bus between the fetch/data requesters, the arbiter and the cache port.
// The arbiter connects through the slave modport; requesters and cache use master.
interface mem_arbiter_if;
  logic        i_re;
  logic [31:0] i_addr;
  logic [31:0] i_dout;
  logic        i_complete;
  logic        d_re;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_din;
  logic [31:0] d_dout;
  logic        d_complete;
  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;
  logic        mem_complete;
  logic        busy;

  modport slave (
    input  i_re, i_addr, d_re, d_we, d_addr, d_din, mem_dout, mem_complete,
    output i_dout, i_complete, d_dout, d_complete,
    output mem_re, mem_we, mem_addr, mem_din, busy
  );

  modport master (
    output i_re, i_addr, d_re, d_we, d_addr, d_din, mem_dout, mem_complete,
    input  i_dout, i_complete, d_dout, d_complete,
    input  mem_re, mem_we, mem_addr, mem_din, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter (instruction fetch vs. data) onto one cache port.
// Data wins contention until fetch has waited STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  state_t      state_q, state_d;
  logic [2:0]  starve_q, starve_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [31:0] i_dout_q, i_dout_d;
  logic [31:0] d_dout_q, d_dout_d;
  logic        i_cmp_q, i_cmp_d;
  logic        d_cmp_q, d_cmp_d;

  logic d_req;
  logic grant_i;
  logic grant_d;

  assign d_req = bus.d_re | bus.d_we;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (state_q == IDLE) begin
      if (d_req && !(bus.i_re && (starve_q == LIMIT))) begin
        grant_d = 1'b1;
      end else if (bus.i_re) begin
        grant_i = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    starve_d   = starve_q;
    mem_re_d   = mem_re_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    i_dout_d   = i_dout_q;
    d_dout_d   = d_dout_q;
    i_cmp_d    = i_cmp_q;
    d_cmp_d    = d_cmp_q;

    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d    = SERVE_I;
          mem_re_d   = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = bus.i_addr;
          mem_din_d  = 32'd0;
          starve_d   = 3'd0;
        end else if (grant_d) begin
          state_d    = SERVE_D;
          // A simultaneous load+store request is served as a store.
          mem_we_d   = bus.d_we;
          mem_re_d   = ~bus.d_we;
          mem_addr_d = bus.d_addr;
          mem_din_d  = bus.d_din;
          if (bus.i_re && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
          end
        end
      end
      SERVE_I: begin
        if (bus.mem_complete) begin
          state_d  = DONE;
          i_dout_d = bus.mem_dout;
          i_cmp_d  = 1'b1;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      SERVE_D: begin
        if (bus.mem_complete) begin
          state_d  = DONE;
          d_dout_d = bus.mem_dout;
          d_cmp_d  = 1'b1;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
        end
      end
      DONE: begin
        state_d = IDLE;
        i_cmp_d = 1'b0;
        d_cmp_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      starve_q   <= 3'd0;
      mem_re_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_din_q  <= 32'd0;
      i_dout_q   <= 32'd0;
      d_dout_q   <= 32'd0;
      i_cmp_q    <= 1'b0;
      d_cmp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      mem_re_q   <= mem_re_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      i_dout_q   <= i_dout_d;
      d_dout_q   <= d_dout_d;
      i_cmp_q    <= i_cmp_d;
      d_cmp_q    <= d_cmp_d;
    end
  end

  assign bus.mem_re     = mem_re_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = mem_din_q;
  assign bus.i_dout     = i_dout_q;
  assign bus.d_dout     = d_dout_q;
  assign bus.i_complete = i_cmp_q;
  assign bus.d_complete = d_cmp_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: hit, miss, store priority, reset abort and
// the data-vs-fetch starvation rotation with STARVE_LIMIT = 4.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_busy"},   32'(bus.busy),       32'd0);
    chk({tag, "_mre"},    32'(bus.mem_re),     32'd0);
    chk({tag, "_mwe"},    32'(bus.mem_we),     32'd0);
    chk({tag, "_maddr"},  bus.mem_addr,        32'd0);
    chk({tag, "_mdin"},   bus.mem_din,         32'd0);
    chk({tag, "_icmp"},   32'(bus.i_complete), 32'd0);
    chk({tag, "_dcmp"},   32'(bus.d_complete), 32'd0);
    chk({tag, "_idout"},  bus.i_dout,          32'd0);
    chk({tag, "_ddout"},  bus.d_dout,          32'd0);
  endtask

  initial begin
    rst              = 1'b1;
    bus.i_re         = 1'b0;
    bus.i_addr       = 32'd0;
    bus.d_re         = 1'b0;
    bus.d_we         = 1'b0;
    bus.d_addr       = 32'd0;
    bus.d_din        = 32'd0;
    bus.mem_dout     = 32'd0;
    bus.mem_complete = 1'b0;

    // Reset state
    tick();
    tick();
    chk_idle_zero("reset");
    rst = 1'b0;

    // Single fetch hit
    bus.i_re         = 1'b1;
    bus.i_addr       = 32'h100;
    bus.mem_complete = 1'b1;
    bus.mem_dout     = 32'hDEADBEEF;
    tick();
    chk("hit_mre",    32'(bus.mem_re),     32'd1);
    chk("hit_mwe",    32'(bus.mem_we),     32'd0);
    chk("hit_maddr",  bus.mem_addr,        32'h100);
    chk("hit_mdin",   bus.mem_din,         32'd0);
    chk("hit_busy",   32'(bus.busy),       32'd1);
    chk("hit_icmp0",  32'(bus.i_complete), 32'd0);
    chk("hit_dcmp0",  32'(bus.d_complete), 32'd0);
    tick();
    chk("hit_icmp1",  32'(bus.i_complete), 32'd1);
    chk("hit_idout",  bus.i_dout,          32'hDEADBEEF);
    chk("hit_dcmp1",  32'(bus.d_complete), 32'd0);
    chk("hit_mre_off", 32'(bus.mem_re),    32'd0);
    tick();
    bus.i_re         = 1'b0;
    bus.mem_complete = 1'b0;
    chk("hit_icmp2",  32'(bus.i_complete), 32'd0);
    chk("hit_busy2",  32'(bus.busy),       32'd0);
    chk("hit_idout_hold", bus.i_dout,      32'hDEADBEEF);
    tick();
    chk("idle_mre",   32'(bus.mem_re),     32'd0);
    chk("idle_busy",  32'(bus.busy),       32'd0);

    // Store miss, ten waiting cycles
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h204;
    bus.d_din  = 32'h55AA;
    tick();
    for (int c = 0; c < 10; c++) begin
      chk("st_mwe",   32'(bus.mem_we),     32'd1);
      chk("st_mre",   32'(bus.mem_re),     32'd0);
      chk("st_maddr", bus.mem_addr,        32'h204);
      chk("st_mdin",  bus.mem_din,         32'h55AA);
      chk("st_dcmp",  32'(bus.d_complete), 32'd0);
      if (c == 9) bus.mem_complete = 1'b1;
      tick();
    end
    chk("st_dcmp1",   32'(bus.d_complete), 32'd1);
    chk("st_icmp",    32'(bus.i_complete), 32'd0);
    chk("st_mwe_off", 32'(bus.mem_we),     32'd0);
    tick();
    bus.d_we         = 1'b0;
    bus.mem_complete = 1'b0;
    chk("st_dcmp2",   32'(bus.d_complete), 32'd0);
    tick();

    // Fetch address changes while waiting on a miss
    bus.i_re   = 1'b1;
    bus.i_addr = 32'h100;
    tick();
    bus.i_addr = 32'h200;
    for (int c = 0; c < 3; c++) begin
      chk("chg_maddr", bus.mem_addr, 32'h100);
      tick();
    end
    chk("chg_maddr_last", bus.mem_addr, 32'h100);
    bus.mem_complete = 1'b1;
    bus.mem_dout     = 32'h12345678;
    tick();
    chk("chg_icmp",   32'(bus.i_complete), 32'd1);
    chk("chg_idout",  bus.i_dout,          32'h12345678);
    tick();
    bus.i_re         = 1'b0;
    bus.mem_complete = 1'b0;
    tick();

    // Load and store together are served as a store
    bus.d_re   = 1'b1;
    bus.d_we   = 1'b1;
    bus.d_addr = 32'h40;
    bus.d_din  = 32'h77;
    tick();
    chk("ldst_mwe",   32'(bus.mem_we),  32'd1);
    chk("ldst_mre",   32'(bus.mem_re),  32'd0);
    chk("ldst_maddr", bus.mem_addr,     32'h40);
    bus.mem_complete = 1'b1;
    tick();
    chk("ldst_dcmp",  32'(bus.d_complete), 32'd1);
    tick();
    bus.d_re         = 1'b0;
    bus.d_we         = 1'b0;
    bus.mem_complete = 1'b0;
    tick();

    // Reset three cycles into a load miss
    bus.d_re   = 1'b1;
    bus.d_addr = 32'h300;
    tick();
    chk("rm_mre",  32'(bus.mem_re), 32'd1);
    tick();
    tick();
    tick();
    rst              = 1'b1;
    bus.mem_complete = 1'b1;
    tick();
    chk_idle_zero("rm");
    rst              = 1'b0;
    bus.mem_complete = 1'b0;
    bus.d_addr       = 32'h308;
    bus.mem_dout     = 32'hCAFEF00D;
    tick();
    chk("rm_dcmp_none", 32'(bus.d_complete), 32'd0);
    chk("rm_new_mre",   32'(bus.mem_re),     32'd1);
    chk("rm_new_maddr", bus.mem_addr,        32'h308);
    bus.mem_complete = 1'b1;
    tick();
    chk("rm_new_dcmp",  32'(bus.d_complete), 32'd1);
    chk("rm_new_ddout", bus.d_dout,          32'hCAFEF00D);
    tick();
    bus.d_re         = 1'b0;
    bus.mem_complete = 1'b0;
    tick();

    // Contention: both held, expect D,D,D,D,I repeating
    bus.i_re         = 1'b1;
    bus.i_addr       = 32'h1000;
    bus.d_re         = 1'b1;
    bus.d_addr       = 32'h2000;
    bus.mem_complete = 1'b1;
    bus.mem_dout     = 32'hA5A5A5A5;
    for (int n = 0; n < 10; n++) begin
      tick();
      chk("cont_grant", bus.mem_addr, (n % 5 == 4) ? 32'h1000 : 32'h2000);
      tick();
      chk("cont_icmp", 32'(bus.i_complete), (n % 5 == 4) ? 32'd1 : 32'd0);
      chk("cont_dcmp", 32'(bus.d_complete), (n % 5 == 4) ? 32'd0 : 32'd1);
      tick();
    end
    bus.i_re         = 1'b0;
    bus.d_re         = 1'b0;
    bus.mem_complete = 1'b0;
    tick();
    chk("end_busy", 32'(bus.busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
